// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO UART: register map, status bit positions
// and the TX/RX state encodings.
package uart_pkg;

    localparam logic [3:0] ADDR_DATA = 4'd0;
    localparam logic [3:0] ADDR_STAT = 4'd1;
    localparam logic [3:0] ADDR_MS   = 4'd2;
    localparam logic [3:0] ADDR_CTRL = 4'd3;
    localparam logic [3:0] ADDR_DIV  = 4'd4;

    localparam int ST_TX_IDLE  = 0;
    localparam int ST_RX_AVAIL = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_RX_OVR   = 3;
    localparam int ST_RX_FERR  = 4;
    localparam int ST_TX_OVF   = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary pointers one bit wider than the address;
// a simultaneous push and pop are both honoured, even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_fifo.sv
// Bus-mapped UART with TX/RX FIFOs, programmable divisor, error flags,
// level interrupt and a free-running millisecond counter.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 48,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int MS_DIV   = 48000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m_sel,
    input  logic [3:0]  m_addr,
    input  logic [31:0] m_data_i,
    output logic [31:0] m_data_o,
    input  logic        m_rd,
    input  logic        m_wr,
    output logic        m_intr_o,
    output logic        TXD,
    input  logic        RXD
);
    logic        rd_q, wr_q, rd_stb, wr_stb;
    logic        tx_push, tx_pop, tx_full, tx_empty, tx_idle;
    logic        rx_push, rx_pop, rx_full, rx_empty, rx_ferr_set, rx_sample;
    logic [7:0]  tx_dout, rx_dout;
    logic        tx_ovf, rx_ovr, rx_ferr, ie_rx, ie_tx;
    logic [15:0] div;
    logic [31:0] ms_timer, ms_counter;
    logic [5:0]  status;
    logic        unused_bits;

    assign unused_bits = ^m_data_i[31:16];

    // Accesses act only on the first cycle of a strobe.
    assign rd_stb  = m_sel & m_rd & ~rd_q;
    assign wr_stb  = m_sel & m_wr & ~wr_q;
    assign tx_push = wr_stb && (m_addr == ADDR_DATA);
    assign rx_pop  = rd_stb && (m_addr == ADDR_DATA);

    tx_state_e   tx_state, tx_next;
    logic [15:0] tx_div, tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_tick;

    rx_state_e   rx_state, rx_next;
    logic [15:0] rx_div, rx_cnt, rx_half;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_brk, rx_tick, rxd_m, rxd_s;

    assign tx_tick = (tx_cnt == tx_div - 16'd1);
    assign tx_idle = tx_empty && (tx_state == TX_IDLE);
    assign rx_tick = (rx_cnt == rx_div - 16'd1);
    assign rx_half = {1'b0, div[15:1]} - 16'd1;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push(tx_push), .pop(tx_pop),
        .din(m_data_i[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push(rx_push), .pop(rx_pop),
        .din(rx_shift), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        status              = '0;
        status[ST_TX_IDLE]  = tx_idle;
        status[ST_RX_AVAIL] = !rx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_RX_FERR]  = rx_ferr;
        status[ST_TX_OVF]   = tx_ovf;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        m_data_o = '0;
        if (m_sel) begin
            case (m_addr)
                ADDR_DATA: m_data_o = rx_empty ? 32'd0 : {24'd0, rx_dout};
                ADDR_STAT: m_data_o = {26'd0, status};
                ADDR_MS:   m_data_o = ms_counter;
                ADDR_CTRL: m_data_o = {30'd0, ie_tx, ie_rx};
                ADDR_DIV:  m_data_o = {16'd0, div};
                default:   m_data_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            tx_ovf     <= 1'b0;
            rx_ovr     <= 1'b0;
            rx_ferr    <= 1'b0;
            ie_rx      <= 1'b0;
            ie_tx      <= 1'b0;
            div        <= 16'(BAUD_DIV);
            ms_timer   <= '0;
            ms_counter <= '0;
            m_intr_o   <= 1'b0;
        end else begin
            rd_q <= m_sel & m_rd;
            wr_q <= m_sel & m_wr;
            if (wr_stb && m_addr == ADDR_CTRL) {ie_tx, ie_rx} <= m_data_i[1:0];
            if (wr_stb && m_addr == ADDR_DIV)
                div <= (m_data_i[15:0] < 16'd2) ? 16'd2 : m_data_i[15:0];
            if (wr_stb && m_addr == ADDR_STAT) begin
                if (m_data_i[ST_TX_OVF])  tx_ovf  <= 1'b0;
                if (m_data_i[ST_RX_FERR]) rx_ferr <= 1'b0;
                if (m_data_i[ST_RX_OVR])  rx_ovr  <= 1'b0;
            end
            // A new error in the same cycle as its clear wins.
            if (tx_push && tx_full && !tx_pop) tx_ovf  <= 1'b1;
            if (rx_push && rx_full && !rx_pop) rx_ovr  <= 1'b1;
            if (rx_ferr_set)                   rx_ferr <= 1'b1;
            if (ms_timer == 32'(MS_DIV - 1)) begin
                ms_timer   <= '0;
                ms_counter <= ms_counter + 32'd1;
            end else begin
                ms_timer <= ms_timer + 32'd1;
            end
            m_intr_o <= (ie_rx & !rx_empty) | (ie_tx & tx_idle) | rx_ovr | rx_ferr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state <= TX_IDLE;
            tx_div   <= 16'(BAUD_DIV);
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_shift <= tx_dout;
                tx_div   <= div;
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else if (tx_state != TX_IDLE) begin
                tx_cnt <= tx_tick ? 16'd0 : tx_cnt + 16'd1;
                if (tx_state == TX_DATA && tx_tick) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 3'd1;
                end
            end
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (!tx_empty) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_next = tx_empty ? TX_IDLE : TX_START;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // The last stop cycle pops the next byte so frames run back to back.
    always_comb begin
        tx_pop = 1'b0;
        TXD    = 1'b1;
        case (tx_state)
            TX_IDLE:  tx_pop = !tx_empty;
            TX_START: TXD    = 1'b0;
            TX_DATA:  TXD    = tx_shift[0];
            TX_STOP:  tx_pop = tx_tick && !tx_empty;
            default:  TXD    = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_m    <= 1'b1;
            rxd_s    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_div   <= 16'(BAUD_DIV);
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_brk   <= 1'b0;
        end else begin
            rxd_m    <= RXD;
            rxd_s    <= rxd_m;
            rx_state <= rx_next;
            if (rx_state == RX_IDLE) begin
                rx_brk <= 1'b0;
                rx_div <= div;
                rx_bit <= '0;
                rx_cnt <= (rxd_s || rx_next == RX_START) ? 16'd0 : rx_cnt + 16'd1;
            end else begin
                rx_cnt <= rx_tick ? 16'd0 : rx_cnt + 16'd1;
                if (rx_sample) begin
                    rx_shift <= {rxd_s, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
                if (rx_ferr_set) rx_brk <= 1'b1;
            end
        end
    end

    // Entering START marks mid start bit; each later tick lands mid-bit.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rxd_s && rx_cnt == rx_half) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_brk) begin
                    if (rxd_s) rx_next = RX_IDLE;
                end else if (rx_tick && rxd_s) begin
                    rx_next = RX_IDLE;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_sample   = 1'b0;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state)
            RX_START, RX_DATA: rx_sample = rx_tick;
            RX_STOP: begin
                rx_push     = !rx_brk && rx_tick && rxd_s;
                rx_ferr_set = !rx_brk && rx_tick && !rxd_s;
            end
            default: rx_sample = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Randomised self-checking bench for uart_fifo against a queue-based model
// of the register map and the expected serial waveform.
`timescale 1ns/1ps
module tb_uart_fifo;
    import uart_pkg::*;

    localparam int BAUD_DIV = 4;
    localparam int MS_DIV   = 10;
    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i, m_sel, m_rd, m_wr, m_intr_o, TXD, RXD;
    logic        rxd_drv, loop_en;
    logic [3:0]  m_addr;
    logic [31:0] m_data_i, m_data_o, d;
    logic [7:0]  b;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rst_cyc = 0;
    int rd_cyc = 0;
    int n, zeros;

    logic       txd_hist[$];
    logic [7:0] exp_q[$];
    int         div_q[$];
    logic [7:0] rx_q[$];

    uart_fifo #(
        .BAUD_DIV(BAUD_DIV), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .MS_DIV(MS_DIV)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .m_sel(m_sel), .m_addr(m_addr),
        .m_data_i(m_data_i), .m_data_o(m_data_o), .m_rd(m_rd), .m_wr(m_wr),
        .m_intr_o(m_intr_o), .TXD(TXD), .RXD(RXD)
    );

    always #5 clk_i = ~clk_i;
    assign RXD = loop_en ? TXD : rxd_drv;

    always @(posedge clk_i) cyc <= cyc + 1;
    always @(posedge clk_i) begin
        #1;
        txd_hist.push_back(TXD);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat(input bit ovf, input bit ferr, input bit ovr,
                                         input bit full, input bit avail, input bit idle);
        return {26'd0, ovf, ferr, ovr, full, avail, idle};
    endfunction

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] wd);
        m_addr = a; m_data_i = wd; m_sel = 1'b1; m_wr = 1'b1;
        tick(1);
        m_sel = 1'b0; m_wr = 1'b0;
        tick(1);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] rd);
        m_addr = a; m_sel = 1'b1; m_rd = 1'b1;
        #1;
        rd = m_data_o;
        rd_cyc = cyc;
        tick(1);
        m_sel = 1'b0; m_rd = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick(1);
        check("rst_txd", 32'(TXD), 32'd1);
        rst_i = 1'b0;
        rst_cyc = cyc;
    endtask

    task automatic send_frame(input logic [7:0] fb, input logic stop);
        rxd_drv = 1'b0;
        tick(BAUD_DIV);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = fb[i];
            tick(BAUD_DIV);
        end
        rxd_drv = stop;
        tick(BAUD_DIV);
        rxd_drv = 1'b1;
        tick(BAUD_DIV);
    endtask

    // Expected line: each byte as start/8 data/stop, div samples per bit, frames
    // contiguous from the first low sample, then idle high to the end.
    task automatic check_frames();
        int start, pos, err, sz;
        logic [7:0] dec;
        logic ev;
        sz = txd_hist.size();
        start = -1;
        for (int i = 0; i < sz; i++) begin
            if (txd_hist[i] == 1'b0) begin
                start = i;
                break;
            end
        end
        check("tx_frame_seen", 32'(start >= 0), 32'd1);
        if (start < 0) return;
        pos = start;
        err = 0;
        for (int f = 0; f < exp_q.size(); f++) begin
            dec = '0;
            for (int bi = 0; bi < 10; bi++) begin
                ev = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : exp_q[f][bi-1];
                for (int j = 0; j < div_q[f]; j++) begin
                    if (pos + j >= sz || txd_hist[pos + j] !== ev) err++;
                end
                if (bi >= 1 && bi <= 8 && pos + div_q[f] / 2 < sz)
                    dec[bi-1] = txd_hist[pos + div_q[f] / 2];
                pos += div_q[f];
            end
            check("tx_byte", 32'(dec), 32'(exp_q[f]));
        end
        for (int i = pos; i < sz; i++) begin
            if (txd_hist[i] !== 1'b1) err++;
        end
        check("tx_wave_err", 32'(err), 32'd0);
    endtask

    initial begin
        m_sel = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_data_i = '0;
        rxd_drv = 1'b1; loop_en = 1'b0; rst_i = 1'b0;
        tick(2);
        do_reset();

        bus_read(ADDR_STAT, d); check("rst_status", d, stat(0, 0, 0, 0, 0, 1));
        bus_read(ADDR_DIV, d);  check("rst_div", d, 32'(BAUD_DIV));
        bus_read(ADDR_CTRL, d); check("rst_ctrl", d, 32'd0);
        check("rst_intr", 32'(m_intr_o), 32'd0);
        m_addr = ADDR_STAT; #1;
        check("unselected_zero", m_data_o, 32'd0);
        bus_read(4'd7, d);      check("unmapped_zero", d, 32'd0);

        // Loopback: two fixed bytes, then a random batch.
        loop_en = 1'b1;
        exp_q = {}; div_q = {};
        exp_q.push_back(8'h55); exp_q.push_back(8'hA3);
        div_q.push_back(BAUD_DIV); div_q.push_back(BAUD_DIV);
        txd_hist.delete();
        bus_write(ADDR_DATA, 32'h55);
        bus_write(ADDR_DATA, 32'hA3);
        tick(100);
        check_frames();
        bus_read(ADDR_DATA, d); check("loop_rx0", d, 32'h55);
        bus_read(ADDR_DATA, d); check("loop_rx1", d, 32'hA3);
        bus_read(ADDR_STAT, d); check("loop_status", d, stat(0, 0, 0, 0, 0, 1));

        n = $urandom_range(2, 4);
        exp_q = {}; div_q = {};
        txd_hist.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            div_q.push_back(BAUD_DIV);
            bus_write(ADDR_DATA, {24'd0, b});
        end
        tick(n * 10 * BAUD_DIV + 30);
        check_frames();
        for (int i = 0; i < n; i++) begin
            bus_read(ADDR_DATA, d);
            check("loop_rand_rx", d, 32'(exp_q[i]));
        end
        bus_read(ADDR_DATA, d); check("rx_empty_read", d, 32'd0);
        loop_en = 1'b0;

        // TX overflow: one byte in flight plus TX_DEPTH queued; the rest dropped.
        exp_q = {}; div_q = {};
        txd_hist.delete();
        for (int i = 0; i < TX_DEPTH + 2; i++) begin
            b = 8'($urandom);
            if (i < TX_DEPTH + 1) begin
                exp_q.push_back(b);
                div_q.push_back(BAUD_DIV);
            end
            bus_write(ADDR_DATA, {24'd0, b});
        end
        bus_read(ADDR_STAT, d); check("tx_ovf_set", d, stat(1, 0, 0, 1, 0, 0));
        bus_write(ADDR_STAT, 32'h20);
        bus_read(ADDR_STAT, d); check("tx_ovf_clr", d, stat(0, 0, 0, 1, 0, 0));
        tick((TX_DEPTH + 1) * 10 * BAUD_DIV + 20);
        check_frames();
        bus_read(ADDR_STAT, d); check("tx_drained", d, stat(0, 0, 0, 0, 0, 1));

        // RX overrun: RX_DEPTH+1 frames without reading.
        do_reset();
        rx_q = {};
        for (int i = 0; i < RX_DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (i < RX_DEPTH) rx_q.push_back(b);
            send_frame(b, 1'b1);
        end
        bus_read(ADDR_STAT, d); check("rx_ovr_status", d, stat(0, 0, 1, 0, 1, 1));
        check("rx_ovr_intr", 32'(m_intr_o), 32'd1);
        for (int i = 0; i < RX_DEPTH; i++) begin
            bus_read(ADDR_DATA, d);
            check("rx_ovr_data", d, 32'(rx_q[i]));
        end
        bus_read(ADDR_STAT, d); check("rx_ovr_drained", d, stat(0, 0, 1, 0, 0, 1));
        bus_write(ADDR_STAT, 32'h08);
        bus_read(ADDR_STAT, d); check("rx_ovr_clr", d, stat(0, 0, 0, 0, 0, 1));
        check("rx_ovr_intr_clr", 32'(m_intr_o), 32'd0);

        // Framing error, then a one-cycle glitch, then a good random frame.
        send_frame(8'h3C, 1'b0);
        tick(6);
        bus_read(ADDR_STAT, d); check("ferr_status", d, stat(0, 1, 0, 0, 0, 1));
        check("ferr_intr", 32'(m_intr_o), 32'd1);
        bus_read(ADDR_DATA, d); check("ferr_no_data", d, 32'd0);
        bus_write(ADDR_STAT, 32'h10);
        rxd_drv = 1'b0; tick(1);
        rxd_drv = 1'b1; tick(30);
        bus_read(ADDR_STAT, d); check("glitch_status", d, stat(0, 0, 0, 0, 0, 1));
        b = 8'($urandom);
        send_frame(b, 1'b1);
        bus_read(ADDR_DATA, d); check("rx_after_ferr", d, 32'(b));

        // Divisor clamp and mid-frame change.
        bus_write(ADDR_DIV, 32'd1); bus_read(ADDR_DIV, d); check("div_clamp1", d, 32'd2);
        bus_write(ADDR_DIV, 32'd0); bus_read(ADDR_DIV, d); check("div_clamp0", d, 32'd2);
        n = $urandom_range(2, 65535);
        bus_write(ADDR_DIV, 32'(n)); bus_read(ADDR_DIV, d); check("div_rand", d, 32'(n));
        bus_write(ADDR_DIV, 32'(BAUD_DIV));
        exp_q = {}; div_q = {};
        txd_hist.delete();
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_write(ADDR_DATA, {24'd0, b});
        end
        div_q.push_back(BAUD_DIV); div_q.push_back(8);
        bus_write(ADDR_DIV, 32'd8);
        tick(140);
        check_frames();
        bus_write(ADDR_DIV, 32'(BAUD_DIV));

        // Interrupt enables: tx_ie with idle TX asserts one cycle later.
        bus_write(ADDR_CTRL, 32'd3); bus_read(ADDR_CTRL, d); check("ctrl_rw", d, 32'd3);
        check("intr_tx_ie", 32'(m_intr_o), 32'd1);
        bus_write(ADDR_CTRL, 32'd1);
        check("intr_rx_ie_empty", 32'(m_intr_o), 32'd0);

        // Millisecond counter from reset.
        do_reset();
        tick(35);
        bus_read(ADDR_MS, d); check("ms_35", d, 32'((rd_cyc - rst_cyc) / MS_DIV));
        tick($urandom_range(1, 200));
        bus_read(ADDR_MS, d); check("ms_rand", d, 32'((rd_cyc - rst_cyc) / MS_DIV));

        // A read strobe held for three cycles pops once.
        rx_q = {};
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            rx_q.push_back(b);
            send_frame(b, 1'b1);
        end
        m_addr = ADDR_DATA; m_sel = 1'b1; m_rd = 1'b1;
        #1;
        check("held_read", m_data_o, 32'(rx_q[0]));
        tick(3);
        m_sel = 1'b0; m_rd = 1'b0;
        tick(1);
        bus_read(ADDR_DATA, d); check("held_pop_once", d, 32'(rx_q[1]));
        bus_read(ADDR_STAT, d); check("held_status", d, stat(0, 0, 0, 0, 0, 1));

        // Reset in the middle of a frame with both FIFOs holding data.
        send_frame(8'($urandom), 1'b1);
        bus_write(ADDR_DATA, 32'($urandom));
        bus_write(ADDR_DATA, 32'($urandom));
        tick(10);
        do_reset();
        txd_hist.delete();
        bus_read(ADDR_STAT, d); check("rst_mid_status", d, stat(0, 0, 0, 0, 0, 1));
        bus_read(ADDR_DATA, d); check("rst_mid_rx_empty", d, 32'd0);
        tick(60);
        zeros = 0;
        for (int i = 0; i < txd_hist.size(); i++) begin
            if (txd_hist[i] !== 1'b1) zeros++;
        end
        check("rst_mid_tx_quiet", 32'(zeros), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
